// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and round-robin search for the SPI burst arbiter
package spi_pkg;

  localparam int BYTE_W       = 8;
  localparam int GUARD_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SHIFT,
    GUARD
  } state_t;

  // First set bit of reqs[n-1:0] at or after ptr, wrapping; 0 when nothing is set.
  function automatic logic [2:0] rr_first(input logic [7:0] reqs, input logic [2:0] ptr,
                                          input int unsigned n);
    logic [2:0]  w;
    logic        found;
    int unsigned k;
    w     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      k = (32'(ptr) + i) % n;
      if (i < n && !found && reqs[k[2:0]]) begin
        w     = k[2:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - byte shift register, bit counter, mosi drive and miso capture
// Bit order is LSB first unless SPI_MSB_FIRST_EN is defined.
module spi_byte_engine
  import spi_pkg::*;
(
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              miso,
  output logic              at_bit7,
  output logic              mosi,
  output logic [BYTE_W-1:0] rx_data,
  output logic              byte_done
);

  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] rx_sh;
  logic [BYTE_W-1:0] rx_next;
  logic [2:0]        bit_cnt;
  logic [2:0]        cap_bit;
  logic              cap_en;

  function automatic logic [2:0] bit_idx(input logic [2:0] b);
`ifdef SPI_MSB_FIRST_EN
    return 3'd7 - b;
`else
    return b;
`endif
  endfunction

  assign at_bit7 = (bit_cnt == 3'd7);

  // miso for a bit is sampled one edge after that bit is launched on mosi.
  always_comb begin
    rx_next                   = rx_sh;
    rx_next[bit_idx(cap_bit)] = miso;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      shreg     <= '0;
      rx_sh     <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      cap_bit   <= '0;
      cap_en    <= 1'b0;
      mosi      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      cap_en    <= shift_en;
      cap_bit   <= bit_cnt;
      byte_done <= 1'b0;
      if (cap_en) begin
        rx_sh <= rx_next;
        if (cap_bit == 3'd7) begin
          rx_data   <= rx_next;
          byte_done <= 1'b1;
        end
      end
      if (shift_en) begin
        mosi    <= shreg[bit_idx(bit_cnt)];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (load) begin
        shreg   <= load_data;
        bit_cnt <= '0;
      end
      if (clr) begin
        mosi <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_burst_arbiter.sv
// rtl/spi_burst_arbiter.sv - round-robin arbiter running multi-byte SPI bursts for NUM_REQ requesters
// Shift order selected by SPI_MSB_FIRST_EN inside spi_byte_engine.
module spi_burst_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     tx_data,
  output logic [NUM_REQ-1:0]       tx_ready,
  output logic [7:0]               rx_data,
  output logic [NUM_REQ-1:0]       rx_valid,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       ss_n,
  output logic                     mosi,
  input  logic                     miso
);

  state_t             state;
  state_t             state_next;
  logic [7:0]         req_pad;
  logic [2:0]         win;
  logic [2:0]         owner;
  logic [2:0]         rr_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic [LEN_W-1:0]   win_len;
  logic [LEN_W-1:0]   len_clamp;
  logic [LEN_W-1:0]   len_left;
  logic [1:0]         guard_cnt;
  logic [BYTE_W-1:0]  tx_byte;
  logic               load;
  logic               shift_en;
  logic               clr;
  logic               at_bit7;
  logic               byte_done;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
  end

  assign win      = rr_first(req_pad, rr_ptr, NUM_REQ);
  assign win_oh   = NUM_REQ'(1) << win;
  assign owner_oh = NUM_REQ'(1) << owner;
  assign win_len  = req_len[win*LEN_W +: LEN_W];
  assign tx_byte  = tx_data[owner*BYTE_W +: BYTE_W];
  assign rx_valid = byte_done ? owner_oh : '0;

  always_comb begin
    len_clamp = win_len;
    if (win_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (win_len > LEN_W'(MAX_LEN)) begin
      len_clamp = LEN_W'(MAX_LEN);
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) state_next = SELECT;
      end
      SELECT: begin
        load       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (at_bit7) begin
          if (len_left != '0) load = 1'b1;
          else state_next = GUARD;
        end
      end
      GUARD: begin
        clr = 1'b1;
        if (guard_cnt == 2'(GUARD_CYCLES - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // len_left counts bytes not yet loaded into the shift register.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      grant     <= '0;
      busy      <= 1'b0;
      ss_n      <= '1;
      tx_ready  <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      len_left  <= '0;
      guard_cnt <= '0;
    end else begin
      tx_ready <= '0;
      case (state)
        IDLE: begin
          if (req != '0) begin
            grant    <= win_oh;
            busy     <= 1'b1;
            owner    <= win;
            len_left <= len_clamp;
          end
        end
        SELECT: begin
          ss_n     <= ~owner_oh;
          tx_ready <= owner_oh;
          len_left <= len_left - LEN_W'(1);
        end
        SHIFT: begin
          if (at_bit7 && len_left != '0) begin
            tx_ready <= owner_oh;
            len_left <= len_left - LEN_W'(1);
          end
        end
        GUARD: begin
          guard_cnt <= guard_cnt + 2'd1;
          if (state_next == IDLE) begin
            ss_n      <= '1;
            grant     <= '0;
            busy      <= 1'b0;
            guard_cnt <= '0;
            rr_ptr    <= (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  spi_byte_engine u_engine (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .load      (load),
    .shift_en  (shift_en),
    .clr       (clr),
    .load_data (tx_byte),
    .miso      (miso),
    .at_bit7   (at_bit7),
    .mosi      (mosi),
    .rx_data   (rx_data),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// tb/tb_spi_burst_arbiter.sv - randomized bench for spi_burst_arbiter against a burst-level model
// Bit order follows SPI_MSB_FIRST_EN, matching the design build.
module tb_spi_burst_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 8;
  localparam int LW   = 4;

  logic            sclk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N*8-1:0]  tx_data = '0;
  logic [N-1:0]    tx_ready;
  logic [7:0]      rx_data;
  logic [N-1:0]    rx_valid;
  logic [N-1:0]    grant;
  logic            busy;
  logic [N-1:0]    ss_n;
  logic            mosi;
  logic            miso;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  int hi_run = 100;
  bit mon_en = 1'b0;
  logic [7:0] q[N][8];
  int qi[N];

  assign miso = mosi;

  always #5 sclk = ~sclk;

  spi_burst_arbiter #(.NUM_REQ(N), .MAX_LEN(MAXL)) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .req      (req),
    .req_len  (req_len),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .grant    (grant),
    .busy     (busy),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] rq, input int p);
    for (int i = 0; i < N; i++) if (rq[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  function automatic int model_len(input int l);
    return (l == 0) ? 1 : ((l > MAXL) ? MAXL : l);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 8; j++) q[k][j] = 8'($urandom);
  endtask

  always @(negedge sclk) begin
    if (mon_en) begin
      if (ss_n != '1) begin
        check("ss_onehot", $countones(~ss_n), 1);
        if (hi_run > 0) check("ss_gap", (hi_run >= 2) ? 1 : 0, 1);
        hi_run = 0;
      end else begin
        hi_run++;
      end
    end
  end

  task automatic run_burst(input logic [N-1:0] rq, input logic [N*LW-1:0] lens, input bit drop);
    int w, L, lowcnt, nrdy, nrx, cyc, b;
    logic [7:0] mb[8];
    logic [N-1:0] woh;
    w   = model_pick(rq, ptr_m);
    L   = model_len(int'(lens[w*LW +: LW]));
    woh = 4'b0001 << w;
    for (int k = 0; k < N; k++) begin
      qi[k] = 0;
      tx_data[k*8 +: 8] = q[k][0];
    end
    for (int j = 0; j < 8; j++) mb[j] = '0;
    req     = rq;
    req_len = lens;
    cyc     = 0;
    do begin
      @(negedge sclk);
      cyc++;
    end while (grant == '0 && cyc < 10);
    check("grant", grant, woh);
    if (drop) req[w] = 1'b0;
    lowcnt = 0;
    nrdy   = 0;
    nrx    = 0;
    cyc    = 0;
    while (1) begin
      if (ss_n[w] == 1'b0) begin
        if (lowcnt >= 1 && lowcnt <= 8 * L) begin
          b = lowcnt - 1;
`ifdef SPI_MSB_FIRST_EN
          mb[b / 8][7 - (b % 8)] = mosi;
`else
          mb[b / 8][b % 8] = mosi;
`endif
        end
        lowcnt++;
      end
      if (tx_ready != '0) begin
        check("tx_ready_owner", tx_ready, woh);
        nrdy++;
        qi[w]++;
        if (qi[w] < 8) tx_data[w*8 +: 8] = q[w][qi[w]];
      end
      if (rx_valid != '0) begin
        check("rx_valid_owner", rx_valid, woh);
        if (nrx < 8) check("rx_data", rx_data, q[w][nrx]);
        nrx++;
      end
      if (!busy || cyc > 100) break;
      for (int k = 0; k < N; k++) begin
        if (k != w) begin
          tx_data[k*8 +: 8] = 8'($urandom);
          req_len[k*LW +: LW] = LW'($urandom);
        end
      end
      @(negedge sclk);
      cyc++;
    end
    check("burst_end_busy", busy, 0);
    check("ss_low_cycles", lowcnt, 8 * L + 1);
    check("tx_ready_count", nrdy, L);
    check("rx_valid_count", nrx, L);
    for (int j = 0; j < L; j++) check("mosi_byte", mb[j], q[w][j]);
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    int cyc, lowcnt;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ss_n", ss_n, 4'hF);
    check("rst_mosi", mosi, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    fill_random();
    q[1][0] = 8'hA5;
    q[1][1] = 8'h3C;
    run_burst(4'b0010, 16'h0020, 1'b0);

    for (int i = 0; i < 5; i++) begin
      fill_random();
      run_burst(4'b1111, 16'h1111, 1'b0);
    end

    fill_random();
    run_burst(4'b0001, 16'h0000, 1'b0);
    fill_random();
    run_burst(4'b0001, 16'h000F, 1'b0);

    fill_random();
    run_burst(4'b1000, 16'h3000, 1'b1);

    fill_random();
    q[2][0] = 8'h80;
    run_burst(4'b0100, 16'h0100, 1'b0);

    fill_random();
    for (int k = 0; k < N; k++) tx_data[k*8 +: 8] = q[k][0];
    req     = 4'b0100;
    req_len = 16'h0200;
    cyc     = 0;
    lowcnt  = 0;
    while (lowcnt < 5 && cyc < 40) begin
      @(negedge sclk);
      cyc++;
      if (ss_n[2] == 1'b0) lowcnt++;
    end
    check("reset_reach_shift", lowcnt, 5);
    rst_n = 1'b0;
    @(negedge sclk);
    check("midrst_ss_n", ss_n, 4'hF);
    check("midrst_busy", busy, 0);
    check("midrst_grant", grant, 0);
    check("midrst_rx_valid", rx_valid, 0);
    @(negedge sclk);
    check("midrst_rx_valid2", rx_valid, 0);
    req   = '0;
    ptr_m = 0;
    rst_n = 1'b1;
    fill_random();
    run_burst(4'b0101, 16'h0101, 1'b0);
    fill_random();
    run_burst(4'b0100, 16'h0100, 1'b0);

    for (int i = 0; i < 25; i++) begin
      fill_random();
      run_burst(4'($urandom_range(1, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    req = '0;
    repeat (4) @(negedge sclk);
    check("final_idle_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
